pipelined_shift_unit: RTL and testbench

//  Parametrised, pipelined successor to the 8-bit combinational barrel shifter.

---
 rtl/pipelined_shift_unit.sv | 130 +++++++++++++
 tb/tb_pipelined_shift_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shift_unit.sv
// pipelined_shift_unit: SHW-stage SLL/SRL/SRA/ROR shifter, valid/ready handshake.
// Define PSU_CARRY_EN to add CARRY_OUT (last bit shifted out).
module pipelined_shift_unit #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INPUT,
  input  logic [SHW-1:0]   SHIFT_AMOUNT,
  input  logic [1:0]       OPCODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
`ifdef PSU_CARRY_EN
  output logic             CARRY_OUT,
`endif
  output logic [WIDTH-1:0] OUTPUT
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic adv;
  logic last_v;

  assign adv      = !last_v || OUT_READY;
  assign IN_READY = adv;

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int D = 1 << k;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dat_d;
    logic [WIDTH-1:0] dat_q;
    logic [1:0]       sop;
    logic [1:0]       op_q;
    logic [SHW-1:0]   samt;
    logic [SHW-1:0]   amt_q;
    logic             ssgn;
    logic             sgn_q;
    logic             sv;
    logic             vld_q;
    logic             unused_meta;
`ifdef PSU_CARRY_EN
    logic             scy;
    logic             cy_d;
    logic             cy_q;
`endif

    if (k == 0) begin : g_src
      assign src  = INPUT;
      assign sop  = OPCODE;
      assign samt = SHIFT_AMOUNT;
      assign ssgn = INPUT[WIDTH-1];
      assign sv   = IN_VALID && adv;
`ifdef PSU_CARRY_EN
      assign scy  = 1'b0;
`endif
    end else begin : g_src
      assign src  = g_stg[k-1].dat_q;
      assign sop  = g_stg[k-1].op_q;
      assign samt = g_stg[k-1].amt_q;
      assign ssgn = g_stg[k-1].sgn_q;
      assign sv   = g_stg[k-1].vld_q;
`ifdef PSU_CARRY_EN
      assign scy  = g_stg[k-1].cy_q;
`endif
    end

    assign unused_meta = ^{op_q, amt_q, sgn_q};

    // conditional shift by 2^k with per-opcode fill
    always_comb begin
      dat_d = src;
      if (samt[k]) begin
        unique case (sop)
          OP_SLL:  dat_d = src << D;
          OP_SRL:  dat_d = src >> D;
          OP_SRA:  dat_d = WIDTH'({{WIDTH{ssgn}}, src} >> D);
          default: dat_d = WIDTH'({src, src} >> D);
        endcase
      end
    end

    // stage register, loads from predecessor on global advance
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        dat_q <= '0;
        op_q  <= '0;
        amt_q <= '0;
        sgn_q <= 1'b0;
        vld_q <= 1'b0;
      end else if (adv) begin
        dat_q <= dat_d;
        op_q  <= sop;
        amt_q <= samt;
        sgn_q <= ssgn;
        vld_q <= sv;
      end
    end

`ifdef PSU_CARRY_EN
    // carry takes the last bit this stage pushes out
    always_comb begin
      cy_d = scy;
      if (samt[k])
        cy_d = (sop == OP_SLL) ? src[WIDTH-D] : src[D-1];
    end

    // carry register, advances with the stage
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
        cy_q <= 1'b0;
      else if (adv)
        cy_q <= cy_d;
    end
`endif
  end

  assign last_v    = g_stg[SHW-1].vld_q;
  assign OUT_VALID = last_v;
  assign OUTPUT    = g_stg[SHW-1].dat_q;
`ifdef PSU_CARRY_EN
  assign CARRY_OUT = last_v & g_stg[SHW-1].cy_q;
`endif

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// tb_pipelined_shift_unit: directed + random scoreboard bench.
// Reference model computes results arithmetically; timing from accept age.
module tb_pipelined_shift_unit;

  localparam int SHW = 3;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] INPUT;
  logic [2:0] SHIFT_AMOUNT;
  logic [1:0] OPCODE;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUTPUT;
`ifdef PSU_CARRY_EN
  logic       CARRY_OUT;
`endif

  typedef struct {
    logic [7:0] res;
    logic       cy;
    int         age;
  } item_t;

  item_t q[$];
  int checks  = 0;
  int errors  = 0;
  int retired = 0;

  pipelined_shift_unit #(.WIDTH(8)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .INPUT        (INPUT),
    .SHIFT_AMOUNT (SHIFT_AMOUNT),
    .OPCODE       (OPCODE),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
`ifdef PSU_CARRY_EN
    .CARRY_OUT    (CARRY_OUT),
`endif
    .OUTPUT       (OUTPUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input int n);
    int v;
    int r;
    int s;
    logic c;
    v = int'(a);
    c = 1'b0;
    case (op)
      2'd0: begin
        r = (v << n) & 255;
        if (n > 0) c = ((v >> (8 - n)) & 1) != 0;
      end
      2'd1: begin
        r = v >> n;
        if (n > 0) c = ((v >> (n - 1)) & 1) != 0;
      end
      2'd2: begin
        s = (v >= 128) ? v - 256 : v;
        r = (s >>> n) & 255;
        if (n > 0) c = ((v >> (n - 1)) & 1) != 0;
      end
      default: begin
        r = ((v >> n) | (v << (8 - n))) & 255;
        if (n > 0) c = ((v >> (n - 1)) & 1) != 0;
      end
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic step(input bit iv, input logic [1:0] op,
                      input logic [7:0] a, input logic [2:0] n,
                      input logic [8:0] ex, input bit ordy,
                      output bit acc);
    bit ov;
    bit adv;
    item_t it;
    @(negedge CLK);
    IN_VALID     = iv;
    OPCODE       = op;
    INPUT        = a;
    SHIFT_AMOUNT = n;
    OUT_READY    = ordy;
    #1;
    ov  = (q.size() > 0) && (q[0].age == SHW);
    adv = !ov || ordy;
    chk("out_valid", {31'd0, OUT_VALID}, {31'd0, ov});
    chk("in_ready", {31'd0, IN_READY}, {31'd0, adv});
    if (ov) begin
      chk("output", {24'd0, OUTPUT}, {24'd0, q[0].res});
`ifdef PSU_CARRY_EN
      chk("carry", {31'd0, CARRY_OUT}, {31'd0, q[0].cy});
`endif
    end
    acc = iv && adv;
    @(posedge CLK);
    if (adv) begin
      if (ov) begin
        void'(q.pop_front());
        retired++;
      end
      foreach (q[i]) q[i].age++;
      if (acc) begin
        it.res = ex[7:0];
        it.cy  = ex[8];
        it.age = 1;
        q.push_back(it);
      end
    end
  endtask

  initial begin
    bit acc;
    int acc_n;
    int guard;
    logic [1:0] op;
    logic [7:0] a;
    logic [2:0] n;

    RESET_N = 1'b0;
    IN_VALID = 1'b0;
    INPUT = '0;
    SHIFT_AMOUNT = '0;
    OPCODE = '0;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("reset_output", {24'd0, OUTPUT}, 32'd0);
`ifdef PSU_CARRY_EN
    chk("reset_carry", {31'd0, CARRY_OUT}, 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;

    step(0, 2'd0, 8'h00, 3'd0, 9'h000, 1, acc);
    step(1, 2'd0, 8'h10, 3'd2, 9'h040, 1, acc);
    step(1, 2'd0, 8'h04, 3'd2, 9'h010, 1, acc);
    repeat (4) step(0, 2'd0, 8'hA5, 3'd5, 9'h000, 1, acc);

    step(1, 2'd1, 8'h04, 3'd2, 9'h001, 1, acc);
    step(1, 2'd2, 8'h90, 3'd3, 9'h0F2, 1, acc);
    step(1, 2'd2, 8'h70, 3'd3, 9'h00E, 1, acc);
    step(1, 2'd3, 8'h81, 3'd1, 9'h1C0, 1, acc);
    step(1, 2'd3, 8'h5A, 3'd0, 9'h05A, 1, acc);
    step(1, 2'd0, 8'hFF, 3'd7, 9'h180, 1, acc);
    repeat (4) step(0, 2'd0, 8'h00, 3'd0, 9'h000, 1, acc);

    step(1, 2'd0, 8'h01, 3'd1, 9'h002, 0, acc);
    step(1, 2'd0, 8'h01, 3'd2, 9'h004, 0, acc);
    step(1, 2'd0, 8'h01, 3'd3, 9'h008, 0, acc);
    repeat (2) step(1, 2'd1, 8'hEE, 3'd4, 9'h000, 0, acc);
    chk("bp_stalled_depth", q.size(), 32'd3);
    retired = 0;
    repeat (4) step(0, 2'd0, 8'h00, 3'd0, 9'h000, 1, acc);
    chk("bp_released", retired, 32'd3);

    step(1, 2'd0, 8'h11, 3'd1, 9'h022, 1, acc);
    step(1, 2'd0, 8'h03, 3'd1, 9'h006, 1, acc);
    step(0, 2'd0, 8'h00, 3'd0, 9'h000, 0, acc);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("midreset_output", {24'd0, OUTPUT}, 32'd0);
    q.delete();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) step(0, 2'd0, 8'h00, 3'd0, 9'h000, 1, acc);

    acc_n = 0;
    guard = 0;
    retired = 0;
    while (acc_n < 1000 && guard < 20000) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      n  = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, op, a, n,
           ref_op(op, a, int'(n)), $urandom_range(0, 2) != 0, acc);
      if (acc) acc_n++;
      guard++;
    end
    chk("random_accepted", acc_n, 32'd1000);
    repeat (10) step(0, 2'd0, 8'h00, 3'd0, 9'h000, 1, acc);
    chk("random_drained", q.size(), 32'd0);
    chk("random_retired", retired, 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
